// File: rtl/rc4_stream_xor_ctrl.sv
// RC4 keystream consumer: requests S-array generation, then XORs each ciphertext byte with one
// freshly requested keystream byte and hands the plaintext out on a valid/ready interface.
module rc4_stream_xor_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  msg_len_i,
    output logic              genStateArr_o,
    input  logic              sarrGenerated_i,
    output logic              genVal_o,
    input  logic              valReady_i,
    input  logic [DATA_W-1:0] keystream_i,
    input  logic              cipher_valid_i,
    output logic              cipher_ready_o,
    input  logic [DATA_W-1:0] cipher_i,
    output logic              plain_valid_o,
    input  logic              plain_ready_i,
    output logic [DATA_W-1:0] plain_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [LEN_W-1:0]  bytes_left_o
);

    localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StInitReq, StInitWait, StByteWait, StKsReq, StKsWait, StOut, StDone, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [LEN_W-1:0]  bytes_left_q, bytes_left_d;
    logic [DATA_W-1:0] cipher_q, cipher_d;
    logic [DATA_W-1:0] plain_q, plain_d;
    logic              error_q, error_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            bytes_left_q <= '0;
            cipher_q     <= '0;
            plain_q      <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bytes_left_q <= bytes_left_d;
            cipher_q     <= cipher_d;
            plain_q      <= plain_d;
            error_q      <= error_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = '0;
        bytes_left_d = bytes_left_q;
        cipher_d     = cipher_q;
        plain_d      = plain_q;
        error_d      = error_q;
        done_d       = 1'b0;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    bytes_left_d = msg_len_i;
                    error_d      = 1'b0;
                    if (msg_len_i == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StInitReq;
                    end
                end
            end
            StInitReq: state_d = StInitWait;
            StInitWait: begin
                if (sarrGenerated_i) begin
                    state_d = StByteWait;
                end else if (timer_q == TmrMax) begin
                    state_d = StErr;
                    error_d = 1'b1;
                end
            end
            StByteWait: begin
                if (cipher_valid_i) begin
                    cipher_d = cipher_i;
                    state_d  = StKsReq;
                end
            end
            StKsReq: state_d = StKsWait;
            StKsWait: begin
                // A keystream byte arriving on the last timer count still wins over the timeout.
                if (valReady_i) begin
                    plain_d = cipher_q ^ keystream_i;
                    if (bytes_left_q != '0) begin
                        bytes_left_d = bytes_left_q - 1'b1;
                    end
                    state_d = StOut;
                end else if (timer_q == TmrMax) begin
                    state_d = StErr;
                    error_d = 1'b1;
                end
            end
            StOut: begin
                if (plain_ready_i) begin
                    if (bytes_left_q == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StByteWait;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Timer only runs while parked in a wait state; any entry sees it at zero.
        if ((state_q == StInitWait || state_q == StKsWait) && state_d == state_q) begin
            timer_d = (timer_q == TmrMax) ? timer_q : timer_q + 1'b1;
        end
    end

    always_comb begin
        genStateArr_o  = 1'b0;
        genVal_o       = 1'b0;
        cipher_ready_o = 1'b0;
        plain_valid_o  = 1'b0;
        busy_o         = 1'b1;
        unique case (state_q)
            StInitReq:             genStateArr_o  = 1'b1;
            StByteWait:            cipher_ready_o = 1'b1;
            StKsReq:               genVal_o       = 1'b1;
            StOut:                 plain_valid_o  = 1'b1;
            StIdle, StDone, StErr: busy_o         = 1'b0;
            default:               busy_o         = 1'b1;
        endcase
    end

    assign plain_o      = plain_q;
    assign bytes_left_o = bytes_left_q;
    assign error_o      = error_q;
    assign done_o       = done_q;

endmodule
